// File: rtl/simplebus_sram_responder.sv
// simplebus_sram_responder: single-port SimpleBus slave memory with a fixed-latency pipeline
// and an in-order response FIFO whose depth bounds the number of outstanding requests.
module simplebus_sram_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_bits_addr,
    input  logic [2:0]  req_bits_size,
    input  logic [3:0]  req_bits_cmd,
    input  logic [3:0]  req_bits_wmask,
    input  logic [31:0] req_bits_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [3:0]  resp_bits_cmd,
    output logic [63:0] resp_bits_rdata
);
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int PL = LATENCY > 1 ? LATENCY - 1 : 1;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] data;
    } rsp_t;

    logic [31:0]   mem_q [WORDS];
    logic [PL-1:0] pv_q, pv_d;
    rsp_t          pd_q [PL];
    rsp_t          pd_d [PL];
    rsp_t          fifo_q [DEPTH];
    rsp_t          fifo_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW-1:0] cnt_q, cnt_d, outs_q, outs_d;
    logic          acc, pop, wr, push;
    logic [IW-1:0] idx;
    logic [31:0]   rd_word, wword_d;
    rsp_t          in_rsp, push_rsp, head;
    logic          unused_ok;

    assign unused_ok = ^{req_bits_size, req_bits_cmd[3:1], req_bits_addr[31:IW+2], req_bits_addr[1:0]};

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        req_ready       = outs_q != AW'(DEPTH);
        resp_valid      = cnt_q != '0;
        head            = fifo_q[rp_q];
        resp_bits_cmd   = resp_valid ? head.cmd : 4'h0;
        resp_bits_rdata = resp_valid ? {head.data, head.data} : 64'h0;
        acc             = req_valid & req_ready;
        pop             = resp_valid & resp_ready;
        idx             = req_bits_addr[IW+1:2];
        rd_word         = mem_q[idx];
        wr              = acc & req_bits_cmd[0];
        wword_d         = rd_word;
        for (int i = 0; i < 4; i++)
            wword_d[8*i +: 8] = req_bits_wmask[i] ? req_bits_wdata[8*i +: 8] : rd_word[8*i +: 8];
        in_rsp.cmd  = wr ? 4'b0101 : 4'b0110;
        in_rsp.data = wr ? 32'h0 : rd_word;
        // Acceptance cycle is the first latency stage; registered stages hold the rest.
        pv_d    = '0;
        pv_d[0] = acc && (LATENCY > 1);
        pd_d[0] = in_rsp;
        for (int i = 1; i < PL; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
        push     = LATENCY == 1 ? acc : pv_q[PL-1];
        push_rsp = LATENCY == 1 ? in_rsp : pd_q[PL-1];
        fifo_d   = fifo_q;
        if (push) fifo_d[wp_q] = push_rsp;
        wp_d   = push ? nxt(wp_q) : wp_q;
        rp_d   = pop ? nxt(rp_q) : rp_q;
        cnt_d  = cnt_q + AW'(push) - AW'(pop);
        outs_d = outs_q + AW'(acc) - AW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
            pv_q   <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            outs_q <= '0;
        end else begin
            if (wr) mem_q[idx] <= wword_d;
            pv_q   <= pv_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            outs_q <= outs_d;
        end
    end

    always_ff @(posedge clock) begin
        pd_q   <= pd_d;
        fifo_q <= fifo_d;
    end

    logic [31:0] inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PL; i++) inflight = inflight + 32'(pv_q[i]);
    end

    // Every outstanding request lives either in the pipeline or in the FIFO.
    always_ff @(posedge clock)
        if (!reset) assert (32'(cnt_q) + inflight == 32'(outs_q));

endmodule

// File: doc/simplebus_sram_responder.md
# simplebus_sram_responder

Single-port SimpleBus slave memory model that sits directly downstream of the core's `io_dmem_mem_*` / `io_imem_mem_*` master ports. It supplies the core's memory side in simulation and bounded formal runs. Each instance accepts single-beat read and write requests, applies writes to a word-organised internal array, and returns responses in order after a fixed pipeline latency. A bounded response queue provides back-pressure on `req_ready`.

## Interface
Parameters:
- `WORDS`, 1024: number of 32-bit storage words; power of two. Index is `req_bits_addr[log2(WORDS)+1:2]`.
- `LATENCY`, 2: cycles from request acceptance to the earliest `resp_valid`; must be ≥1.
- `DEPTH`, 4: maximum outstanding requests (in flight plus queued); power of two, ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: slave can accept a request this cycle.
- `req_bits_addr` input 32: byte address; bits [1:0] ignored.
- `req_bits_size` input 3: access size; ignored, because `wmask` governs writes.
- `req_bits_cmd` input 4: `cmd[0]=1` is a write; `cmd[0]=0` is a read. Burst and probe encodings are treated as single beats.
- `req_bits_wmask` input 4: byte enables for writes.
- `req_bits_wdata` input 32: write data.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: master accepts the response.
- `resp_bits_cmd` output 4: `4'b0110` (readLast) for reads, `4'b0101` (writeResp) for writes.
- `resp_bits_rdata` output 64: read word replicated as `{word, word}`; zero for write responses.

## Operation
- Accept condition: `acc = req_valid & req_ready`.
- Outstanding counter `outs`:
  - Width is log2(DEPTH)+1.
  - `req_ready = (outs != DEPTH)`.
  - `outs` increments on `acc` and decrements on `pop = resp_valid & resp_ready`. When both occur in the same cycle it is unchanged.
- Write on `acc`: each byte `i` of `mem[idx]` is updated from `wdata[8i+7:8i]` when `wmask[i]`. If `wmask=0`, memory is unchanged but a writeResp is still returned.
- Read on `acc`: `mem[idx]` is sampled in the acceptance cycle. It reflects every write accepted in earlier cycles.
- Latency pipeline:
  - `LATENCY` stages, each holding {valid, cmd, rdata}, advancing every cycle.
  - Stages never stall. The last stage pushes into the response FIFO.
- Response FIFO:
  - `DEPTH` entries with circular read and write pointers and an entry count.
  - The head drives the `resp_*` outputs.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Pop when the FIFO holds one entry and no push: `resp_valid` drops the next cycle.
  - Entries in pipeline plus FIFO always equal `outs`, so the FIFO never overflows. Verification asserts this invariant.
- Address aliasing: addresses beyond WORDS×4 wrap modulo the array size. There is no error response.
- Ordering: responses are strictly in acceptance order.

## Timing
- Reset values:
  - `req_ready=1`, `resp_valid=0`, `resp_bits_cmd=0`, `resp_bits_rdata=0`.
  - `outs`, FIFO pointers, count, and all pipeline valid bits are 0.
  - All memory words are 0.
- Reset mid-operation: every in-flight and queued response is discarded; no response is produced for it. Memory is cleared. `req_ready=1` in the cycle after reset is deasserted.
- Accept at cycle t: `resp_valid=1` at cycle t+LATENCY at the earliest, when the FIFO is empty. If the FIFO is occupied, the response follows the queued ones.
- Response stability: while `resp_valid=1` and `resp_ready=0`, `resp_*` hold stable.
- Throughput with `resp_ready` held high: one request per cycle sustained, provided DEPTH ≥ LATENCY+1. Otherwise `req_ready` drops periodically.
- Full: `outs==DEPTH` gives `req_ready=0`. A pop in cycle c raises `req_ready` in cycle c+1. `req_ready` is registered off `outs` and is not combinationally dependent on `resp_ready`.
- Outputs depend only on state; there are no combinational paths from inputs.

## Test plan
- Reset then idle:
  - Hold `reset` high for 2 cycles, then release.
  - `req_ready=1` and `resp_valid=0`.
  - A read of address 0x10 returns `cmd=0110`, `rdata=0` at t+2.
- Write then read:
  - Write addr 0x40, `wdata=0xDEADBEEF`, `wmask=0xF`, then read 0x40 the next cycle.
  - Responses in order: `0101` with rdata 0, then `0110` with rdata `0xDEADBEEF_DEADBEEF`.
- Partial write:
  - Write 0x40 with `wdata=0x11223344`, `wmask=0b0101`, after the previous test.
  - A subsequent read returns word `0xDE22BE44`.
- Back-pressure and full:
  - Hold `resp_ready=0` and issue 5 back-to-back reads.
  - 4 are accepted and `req_ready=0` from the cycle after the 4th accept; the 5th waits.
  - Raise `resp_ready`: 4 responses drain in order, `req_ready` returns the cycle after the first pop, and the 5th is accepted.
- Aliasing:
  - Write 0x1000_0040 with `0xCAFEF00D`, WORDS=1024.
  - A read of 0x40 returns `0xCAFEF00D` replicated.
- Reset mid-flight:
  - Accept 3 reads, assert `reset` at t+1.
  - No `resp_valid` follows, `req_ready=1` after reset, and memory reads back 0.
